// File: rtl/mips_mem_responder.sv
// mips_mem_responder: data-memory responder for the MIPS core.
// Takes one byte-addressed 4-lane access at a time, completes it after LATENCY
// cycles and pulses mem_ready (plus mem_err for out-of-range addresses).
// Lanes are big-endian: lane 0 is the byte at addr, lane 3 the byte at addr+3.
module mips_mem_responder #(
  parameter int MEM_BYTES = 4096,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  input  logic        mem_write_en,
  input  logic [7:0]  mem_data_in  [0:3],
  output logic [7:0]  mem_data_out [0:3],
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        mem_err
);

  localparam int          AW       = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [31:0] LAST_OK  = 32'(MEM_BYTES - 4);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [31:0]   cap_addr;
  logic          cap_we;
  logic [7:0]    cap_data [0:3];
  logic [7:0]    store    [0:MEM_BYTES-1];
  logic [AW-1:0] lane_idx [0:3];

  logic accept, done, oor;

  // New requests are taken only when no access is outstanding (IDLE) or in the
  // response cycle (back-to-back); requests during WAIT are dropped.
  assign accept = mem_req && (state == S_IDLE || state == S_RESP);
  assign done   = (state == S_WAIT) && (cnt == 4'd0);
  // Full-width unsigned compare: huge addresses never wrap into range.
  assign oor    = cap_addr > LAST_OK;

  // Per-lane storage index; only used when in range, so truncation is safe.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lane_idx[i] = cap_addr[AW-1:0] + AW'(i);
  end

  // Control FSM plus registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      mem_ready <= 1'b0;
      mem_busy  <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            state    <= S_WAIT;
            cnt      <= CNT_LOAD;
            mem_busy <= 1'b1;
          end else begin
            state    <= S_IDLE;
            mem_busy <= 1'b0;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state     <= S_RESP;
            mem_ready <= 1'b1;
            mem_err   <= oor;
            mem_busy  <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          cnt      <= 4'd0;
          mem_busy <= 1'b0;
        end
      endcase
    end
  end

  // Operand capture on acceptance; frozen for the rest of the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_addr <= 32'd0;
      cap_we   <= 1'b0;
      for (int i = 0; i < 4; i++) cap_data[i] <= 8'h00;
    end else if (accept) begin
      cap_addr <= mem_addr;
      cap_we   <= mem_write_en;
      for (int i = 0; i < 4; i++) cap_data[i] <= mem_data_in[i];
    end
  end

  // Storage write at the completion edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (done && cap_we && !oor) begin
      for (int i = 0; i < 4; i++) store[lane_idx[i]] <= cap_data[i];
    end
  end

  // Read data register: loaded on completed reads, zeroed for out-of-range reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem_data_out[i] <= 8'h00;
    end else if (done && !cap_we) begin
      for (int i = 0; i < 4; i++) mem_data_out[i] <= oor ? 8'h00 : store[lane_idx[i]];
    end
  end

endmodule
